multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle FSM controller that sequences the shared datapath: one ALU, one unified memory, IR/MDR/A/B/ALUOut regs.
//  Decodes OP/funct once per instruction and drives per-state mux selects and write enables.
//  Covers ADDU, SUBU, ORI, LW, SW, BEQ, JAL. Stretches memory states until the memory handshake completes.
// PARAMETERS
//  STATE_W   4   width of the state register and the debug state output
//  CNT_W     32  width of the performance counters (only present with MCTRL_PERF_CNT_EN)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  OP           in   6      IR[31:26]; valid from DECODE onward
//  funct        in   6      IR[5:0]
//  Zero         in   1      ALU zero flag (BEQ compare)
//  mem_ready    in   1      memory done: read data valid / write accepted this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load qualified by Zero (BEQ)
//  PCSrc        out  2      00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
//  IorD         out  1      memory address: 0 PC, 1 ALUOut
//  IRWrite      out  1      latch instruction register
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  RegWrite     out  1      register file write
//  RegDst       out  2      00 rt, 01 rd, 10 $31
//  Mem2Reg      out  2      00 ALUOut, 01 MDR, 10 PC (return address)
//  ALUSrcA      out  1      0 PC, 1 A
//  ALUSrcB      out  2      00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  EXTOp        out  2      00 sign-extend, 01 zero-extend (ORI)
//  ALUOp        out  2      00 ADDU, 01 SUBU, 10 OR
//  illegal_op   out  1      one-cycle pulse in DECODE for an unsupported OP or R-type funct
//  state        out  STATE_W  current state (debug)
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, IEXEC=8, IWB=9, BRANCH=10, JAL=11.
//  Reset: async; state<=FETCH. While reset=1 every output is 0, including state=0.
//  Outputs: Moore decode of state, except where gated by mem_ready; every output not listed for a state is 0.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
//    IRWrite=PCWrite=mem_ready; stay in FETCH until mem_ready=1, then go to DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next state by opcode:
//    R(000000) with funct 100001 -> REXEC; R with funct 100011 -> REXEC; ORI(001101) -> IEXEC;
//    LW(100011) and SW(101011) -> MEMADR; BEQ(000100) -> BRANCH; JAL(000011) -> JAL.
//    Any other opcode or funct: illegal_op=1 for that cycle, then FETCH (executes as a NOP).
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD for LW, MEMWR for SW.
//  MEMRD: MemRead=1, IorD=1; hold until mem_ready, then MEMWB.
//  MEMWB: RegWrite=1, RegDst=00, Mem2Reg=01; then FETCH.
//  MEMWR: MemWrite=1, IorD=1; hold until mem_ready, then FETCH. Exactly one write is accepted.
//  REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=00 for ADDU / 01 for SUBU; then RWB.
//  RWB: RegWrite=1, RegDst=01, Mem2Reg=00; then FETCH.
//  IEXEC: ALUSrcA=1, ALUSrcB=10, EXTOp=01, ALUOp=10; then IWB.
//  IWB: RegWrite=1, RegDst=00, Mem2Reg=00; then FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01; then FETCH.
//  JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, Mem2Reg=10 (PC already holds PC+4); then FETCH.
//  CPI with mem_ready=1 in its first cycle: LW 5, SW 4, R/ORI 4, BEQ 3, JAL 3. Each wait cycle adds 1.
//  Reset asserted mid-instruction aborts it immediately; no partial RegWrite or MemWrite after reset asserts.
//  mem_ready is ignored in non-memory states. Undefined state encodings (12-15) go to FETCH on the next clock.
// CONFIGURATION
//  MCTRL_PERF_CNT_EN defined:
//    Adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0]; both reset to 0.
//    cycle_cnt increments on every clock after reset.
//    instr_cnt increments on every transition into FETCH from a non-FETCH state, including illegal ops.
//    Both wrap modulo 2^CNT_W.
//  MCTRL_PERF_CNT_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  ADDU (OP=0, funct=0x21), mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 only in RWB with RegDst=01.
//  LW (OP=0x23), mem_ready low 2 cycles in MEMRD -> MEMRD lasts 3 cycles; total 7 cycles;
//    MemWrite=0 throughout; RegWrite pulses once with Mem2Reg=01.
//  BEQ (OP=0x04) with Zero=1, then Zero=0 -> PCWriteCond=1 and PCSrc=01 in BRANCH both times; 3 cycles each.
//  JAL (OP=0x03) -> in state 11: PCWrite=1, PCSrc=10, RegDst=10, Mem2Reg=10, RegWrite=1.
//  OP=0x3F, then R-type funct=0x00 -> illegal_op pulses 1 cycle in DECODE each time; FETCH next; no writes.
//  SW in MEMWR with mem_ready=0, reset asserted -> all outputs 0 immediately;
//    after release FETCH with MemRead=1; with MCTRL_PERF_CNT_EN both counters are 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for a shared-datapath MIPS subset.
// It covers ADDU, SUBU, ORI, LW, SW, BEQ and JAL.
// The FSM decodes OP/funct once in DECODE. After that it drives the mux selects
// and write enables for each state.
// FETCH, MEMRD and MEMWR are held until mem_ready completes the memory handshake.
// Optional feature: define MCTRL_PERF_CNT_EN to add the cycle_cnt and instr_cnt
// performance counters and the CNT_W parameter.
module multicycle_ctrl #(
    parameter int STATE_W = 4
`ifdef MCTRL_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic [5:0]         funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         Mem2Reg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         EXTOp,
    output logic [1:0]         ALUOp,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
`ifdef MCTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt
`endif
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_REXEC  = STATE_W'(6),
        S_RWB    = STATE_W'(7),
        S_IEXEC  = STATE_W'(8),
        S_IWB    = STATE_W'(9),
        S_BRANCH = STATE_W'(10),
        S_JAL    = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    state_t cur_state;
    state_t next_state;

    // The decoded instruction class is captured in DECODE. Later states then do
    // not depend on OP/funct staying stable.
    logic dec_sw;
    logic dec_sub;

    // Branch resolution is done in the datapath: PCWriteCond is ANDed with Zero there.
    logic unused_zero;
    assign unused_zero = Zero;

    assign state = cur_state;

    // State register: reset aborts any instruction in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Capture the instruction class once, while the FSM is in DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_sw  <= 1'b0;
            dec_sub <= 1'b0;
        end else if (cur_state == S_DECODE) begin
            dec_sw  <= (OP == OP_SW);
            dec_sub <= (funct == FN_SUBU);
        end
    end

    // Next-state and Moore outputs. Every output is forced low while reset is high.
    always_comb begin
        next_state  = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        Mem2Reg     = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        EXTOp       = 2'b00;
        ALUOp       = 2'b00;
        illegal_op  = 1'b0;
        if (!reset) begin
            case (cur_state)
                S_FETCH: begin
                    MemRead    = 1'b1;
                    ALUSrcB    = 2'b01;
                    IRWrite    = mem_ready;
                    PCWrite    = mem_ready;
                    next_state = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (OP)
                        OP_RTYPE: begin
                            if (funct == FN_ADDU || funct == FN_SUBU) begin
                                next_state = S_REXEC;
                            end else begin
                                illegal_op = 1'b1;
                                next_state = S_FETCH;
                            end
                        end
                        OP_ORI:        next_state = S_IEXEC;
                        OP_LW, OP_SW:  next_state = S_MEMADR;
                        OP_BEQ:        next_state = S_BRANCH;
                        OP_JAL:        next_state = S_JAL;
                        default: begin
                            illegal_op = 1'b1;
                            next_state = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    next_state = dec_sw ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    MemRead    = 1'b1;
                    IorD       = 1'b1;
                    next_state = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    Mem2Reg    = 2'b01;
                    next_state = S_FETCH;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    next_state = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_REXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = dec_sub ? 2'b01 : 2'b00;
                    next_state = S_RWB;
                end
                S_RWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b01;
                    next_state = S_FETCH;
                end
                S_IEXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    EXTOp      = 2'b01;
                    ALUOp      = 2'b10;
                    next_state = S_IWB;
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSrc       = 2'b01;
                    next_state  = S_FETCH;
                end
                S_JAL: begin
                    PCWrite    = 1'b1;
                    PCSrc      = 2'b10;
                    RegWrite   = 1'b1;
                    RegDst     = 2'b10;
                    Mem2Reg    = 2'b10;
                    next_state = S_FETCH;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

`ifdef MCTRL_PERF_CNT_EN
    // Free-running cycle counter; wraps modulo 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // Retired-instruction counter: one count per return to FETCH, illegal ops included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt <= '0;
        end else if (cur_state != S_FETCH && next_state == S_FETCH) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. Each instruction pushes its expected
// per-cycle state/control words. Each clock then pops one word and compares it.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite;
    logic       ALUSrcA, illegal_op;
    logic [1:0] PCSrc, RegDst, Mem2Reg, ALUSrcB, EXTOp, ALUOp;
    logic [3:0] state;
`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .OP(OP), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .Mem2Reg(Mem2Reg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
`ifdef MCTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem2reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] ext_op;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          ins   = 0;
    logic [31:0] exp_q[$];
    logic        mr_q[$];
    string       tag_q[$];
    logic [5:0]  rnd_op[8];
    logic [5:0]  rnd_fn[8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected control word for a state, written directly from the state table.
    function automatic ctrl_t model(input int st, input logic mr, input logic [5:0] op,
                                    input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (st)
            0: begin
                c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                c.ir_write = mr;   c.pc_write  = mr;
            end
            1: begin
                c.alu_src_b = 2'b11;
                c.illegal = !((op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) ||
                              op == 6'h0D || op == 6'h23 || op == 6'h2B ||
                              op == 6'h04 || op == 6'h03);
            end
            2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            4:  begin c.reg_write = 1'b1; c.mem2reg = 2'b01; end
            5:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
            6:  begin c.alu_src_a = 1'b1; c.alu_op = (fn == 6'h23) ? 2'b01 : 2'b00; end
            7:  begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
            8:  begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                c.ext_op = 2'b01;   c.alu_op = 2'b10;
            end
            9:  c.reg_write = 1'b1;
            10: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_src = 2'b01;
            end
            11: begin
                c.pc_write = 1'b1; c.pc_src = 2'b10; c.reg_write = 1'b1;
                c.reg_dst = 2'b10; c.mem2reg = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] dut_word();
        return {7'b0, state, PCWrite, PCWriteCond, PCSrc, IorD, IRWrite, MemRead,
                MemWrite, RegWrite, RegDst, Mem2Reg, ALUSrcA, ALUSrcB, EXTOp, ALUOp,
                illegal_op};
    endfunction

    task automatic push(input string name, input int st, input logic mr,
                        input logic [5:0] op, input logic [5:0] fn);
        exp_q.push_back({7'b0, 4'(st), model(st, mr, op, fn)});
        mr_q.push_back(mr);
        tag_q.push_back($sformatf("%s_s%0d", name, st));
    endtask

    // Apply one mem_ready value per clock and compare the DUT against the queue head.
    // This task is entered and left on a falling edge.
    task automatic drain();
        while (exp_q.size() > 0) begin
            mem_ready = mr_q.pop_front();
            #1;
            check_val(tag_q.pop_front(), dut_word(), exp_q.pop_front());
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw);
        OP = op; funct = fn; Zero = z;
        for (int i = 0; i < fw; i++) push(name, 0, 1'b0, op, fn);
        push(name, 0, 1'b1, op, fn);
        push(name, 1, 1'($urandom_range(0, 1)), op, fn);
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
            push(name, 6, 1'($urandom_range(0, 1)), op, fn);
            push(name, 7, 1'($urandom_range(0, 1)), op, fn);
        end else if (op == 6'h0D) begin
            push(name, 8, 1'($urandom_range(0, 1)), op, fn);
            push(name, 9, 1'($urandom_range(0, 1)), op, fn);
        end else if (op == 6'h23) begin
            push(name, 2, 1'($urandom_range(0, 1)), op, fn);
            for (int i = 0; i < mw; i++) push(name, 3, 1'b0, op, fn);
            push(name, 3, 1'b1, op, fn);
            push(name, 4, 1'($urandom_range(0, 1)), op, fn);
        end else if (op == 6'h2B) begin
            push(name, 2, 1'($urandom_range(0, 1)), op, fn);
            for (int i = 0; i < mw; i++) push(name, 5, 1'b0, op, fn);
            push(name, 5, 1'b1, op, fn);
        end else if (op == 6'h04) begin
            push(name, 10, 1'($urandom_range(0, 1)), op, fn);
        end else if (op == 6'h03) begin
            push(name, 11, 1'($urandom_range(0, 1)), op, fn);
        end
        drain();
        ins++;
`ifdef MCTRL_PERF_CNT_EN
        check_val({name, "_cycle_cnt"}, cycle_cnt, cyc);
        check_val({name, "_instr_cnt"}, instr_cnt, ins);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rnd_op[0] = 6'h00; rnd_fn[0] = 6'h21;
        rnd_op[1] = 6'h00; rnd_fn[1] = 6'h23;
        rnd_op[2] = 6'h0D; rnd_fn[2] = 6'h15;
        rnd_op[3] = 6'h23; rnd_fn[3] = 6'h00;
        rnd_op[4] = 6'h2B; rnd_fn[4] = 6'h3F;
        rnd_op[5] = 6'h04; rnd_fn[5] = 6'h21;
        rnd_op[6] = 6'h03; rnd_fn[6] = 6'h00;
        rnd_op[7] = 6'h00; rnd_fn[7] = 6'h20;

        reset = 1'b1; OP = 6'h00; funct = 6'h00; Zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        check_val("reset_outputs", dut_word(), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0; ins = 0;
`ifdef MCTRL_PERF_CNT_EN
        #1;
        check_val("reset_cycle_cnt", cycle_cnt, 32'd0);
        check_val("reset_instr_cnt", instr_cnt, 32'd0);
        @(negedge clk);
        cyc = 1;
`endif

        run_instr("ADDU",  6'h00, 6'h21, 1'b0, 0, 0);
        run_instr("SUBU",  6'h00, 6'h23, 1'b0, 1, 0);
        run_instr("ORI",   6'h0D, 6'h00, 1'b0, 0, 0);
        run_instr("LW",    6'h23, 6'h00, 1'b0, 0, 2);
        run_instr("SW",    6'h2B, 6'h00, 1'b0, 0, 1);
        run_instr("BEQ_T", 6'h04, 6'h00, 1'b1, 0, 0);
        run_instr("BEQ_F", 6'h04, 6'h00, 1'b0, 0, 0);
        run_instr("JAL",   6'h03, 6'h00, 1'b0, 0, 0);
        run_instr("ILL_OP", 6'h3F, 6'h21, 1'b0, 0, 0);
        run_instr("ILL_FN", 6'h00, 6'h00, 1'b0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            int idx;
            idx = int'($urandom_range(0, 7));
            run_instr($sformatf("RND%0d", k), rnd_op[idx], rnd_fn[idx],
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
        end

        // Start an SW, stall it in MEMWR, then assert reset mid-cycle.
        OP = 6'h2B; funct = 6'h00;
        push("SWRST", 0, 1'b1, 6'h2B, 6'h00);
        push("SWRST", 1, 1'b0, 6'h2B, 6'h00);
        push("SWRST", 2, 1'b0, 6'h2B, 6'h00);
        push("SWRST", 5, 1'b0, 6'h2B, 6'h00);
        drain();
        mem_ready = 1'b0;
        #1;
        check_val("swrst_stalled", dut_word(), {7'b0, 4'd5, model(5, 1'b0, 6'h2B, 6'h00)});
        #1;
        reset = 1'b1;
        #1;
        check_val("swrst_outputs", dut_word(), 32'h0);
`ifdef MCTRL_PERF_CNT_EN
        check_val("swrst_cycle_cnt", cycle_cnt, 32'd0);
        check_val("swrst_instr_cnt", instr_cnt, 32'd0);
`endif
        @(negedge clk);
        #1;
        check_val("swrst_held", dut_word(), 32'h0);
        reset = 1'b0;
        #1;
        check_val("swrst_release", dut_word(), {7'b0, 4'd0, model(0, 1'b0, 6'h2B, 6'h00)});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
